id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 8-register, 3-bit-address pipeline. It captures decoded operands and control from ID and presents the `id_ex_*` fields that feed the EX stage and the forwarding unit. When a load in EX produces a register that the instruction in ID reads, it inserts a bubble and stalls IF/ID; a branch flush or an EX hold also passes through this stage.

## Interface
- `DATA_W`, 8, operand and immediate width
- `ALUOP_W`, 3, ALU opcode width
- `CNT_W`, 16, statistics counter width (used only with `ID_EX_STATS_EN`)

- `clk` in 1: rising-edge clock
- `rst` in 1: synchronous, active-high reset
- `id_valid` in 1: ID holds a real instruction
- `id_rs`, `id_rt`, `id_rd` in 3: source and destination register addresses
- `id_uses_rt` in 1: the instruction reads `rt`
- `id_regwrite`, `id_memread`, `id_memwrite` in 1: control bits
- `id_alu_op` in ALUOP_W: ALU operation
- `id_rs_data`, `id_rt_data`, `id_imm` in DATA_W: operands
- `flush` in 1: branch taken in EX; kill ID/EX
- `ex_hold` in 1: downstream freeze
- `stall` out 1: holds PC and IF/ID (combinational)
- `id_ex_valid`, `id_ex_regwrite`, `id_ex_memread`, `id_ex_memwrite` out 1: registered control
- `id_ex_rs`, `id_ex_rt`, `id_ex_rd` out 3: registered addresses
- `id_ex_alu_op` out ALUOP_W: registered ALU opcode
- `id_ex_rs_data`, `id_ex_rt_data`, `id_ex_imm` out DATA_W: registered operands
- `stall_count`, `flush_count` out CNT_W: present only with `ID_EX_STATS_EN`

## Operation
- **Load-use condition:** `lu` = `id_valid & id_ex_valid & id_ex_memread & (id_ex_rd!=0) & ((id_ex_rd==id_rs) | (id_uses_rt & id_ex_rd==id_rt))`.
- **Stall output:** `stall` = `(lu | ex_hold) & ~flush`.
- **Register update priority** at each clock edge, highest first:
  1. `rst`: load a bubble.
  2. `flush`: load a bubble.
  3. `ex_hold`: keep all fields unchanged.
  4. `lu`: load a bubble.
  5. Otherwise: load the ID fields, with `id_ex_valid` = `id_valid`.
- **Bubble:** all control bits 0 (`valid`, `regwrite`, `memread`, `memwrite`). All address, opcode and data fields 0.
- **Invalid ID:** when `id_valid`=0, the loaded control bits are forced to 0. This ensures no spurious regwrite reaches the forwarding unit.
- **rd = 0:** a load with `rd`=0 never causes a stall.
- **Stall length:** a load-use stall lasts exactly one cycle. The bubble clears `id_ex_memread`, so `lu` deasserts on the next cycle and the held instruction advances.
- **Simultaneous `flush` and `lu`:** flush wins and `stall`=0. The instruction in ID is flushed upstream as well.

## Timing
- **Reset:** all outputs are 0 the cycle after `rst` is sampled high, including counters.
- **Latency:** 1 cycle from ID inputs to `id_ex_*`.
- **`stall`:** valid in the same cycle. Purely combinational from registered `id_ex_*` and current ID inputs; no path from `stall` back into `lu`.
- **Reset mid-stall:** the stall drops the cycle after reset, because `id_ex_valid`=0.
- **Throughput:** 1 instruction per cycle when there is no hazard.

## Configuration
- **`ID_EX_STATS_EN` defined:**
  - `stall_count` increments on each cycle with `lu & ~flush & ~ex_hold`.
  - `flush_count` increments on each cycle with `flush`.
  - Both saturate at all-ones and clear on `rst`.
- **`ID_EX_STATS_EN` undefined:** the counters and their ports are absent and there is no extra logic.

## Structure
- **Package `pipe_pkg`:**
  - `REG_ADDR_W`=3.
  - Packed struct `id_ex_t` holding all registered fields.
  - Constant `ID_EX_BUBBLE`, the all-zero bubble value.
- **Sub-module `load_use_detect`:** combinational, computes `lu`.
- **This module:** holds the register, the priority mux and the optional counters.

## Test plan
- **Independent instructions:** back-to-back ADDs with rs=1/rt=2, then rs=3/rt=4 → each appears on `id_ex_*` 1 cycle later; `stall`=0 throughout.
- **Load-use on rs:** LW with rd=3 (memread=1) in ID/EX, ADD with rs=3 in ID → `stall`=1 for 1 cycle and ID/EX becomes a bubble. The next cycle loads the ADD, `stall`=0, and `stall_count`=1.
- **Load with rd=0:** LW rd=0 followed by use of rs=0 → no stall.
- **rt not read:** LW rd=5, then an instruction with rt=5 and `id_uses_rt`=0 → no stall.
- **Flush with load-use:** `flush`=1 in the same cycle as a load-use condition → `stall`=0, ID/EX becomes a bubble, `flush_count`=1.
- **Hold and reset:** `ex_hold`=1 for 3 cycles with ADD rs_data=8'hA5 in ID/EX → contents held and `stall`=1. Then `rst` mid-hold → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the ID/EX pipeline register: field widths, the registered
// payload struct and the all-zero bubble value.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W   = 3;
  localparam int unsigned PIPE_DATA_W  = 8;
  localparam int unsigned PIPE_ALUOP_W = 3;

  typedef struct packed {
    logic                    valid;
    logic                    regwrite;
    logic                    memread;
    logic                    memwrite;
    logic [REG_ADDR_W-1:0]   rs;
    logic [REG_ADDR_W-1:0]   rt;
    logic [REG_ADDR_W-1:0]   rd;
    logic [PIPE_ALUOP_W-1:0] alu_op;
    logic [PIPE_DATA_W-1:0]  rs_data;
    logic [PIPE_DATA_W-1:0]  rt_data;
    logic [PIPE_DATA_W-1:0]  imm;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check: a load in EX writing a register that
// the instruction in ID reads. Register 0 never creates a hazard.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_valid,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  lu_c
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = (ex_rd == id_rs);
    rt_hit = id_uses_rt && (ex_rd == id_rt);
    lu_c   = id_valid && ex_valid && ex_memread && (ex_rd != '0) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional saturating stall/flush counters when ID_EX_STATS_EN is defined.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = PIPE_DATA_W,
  parameter int unsigned ALUOP_W = PIPE_ALUOP_W
`ifdef ID_EX_STATS_EN
  ,
  parameter int unsigned CNT_W   = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rt,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_memwrite,
  input  logic [ALUOP_W-1:0]    id_alu_op,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic                  flush,
  input  logic                  ex_hold,
  output logic                  stall,
  output logic                  id_ex_valid,
  output logic                  id_ex_regwrite,
  output logic                  id_ex_memread,
  output logic                  id_ex_memwrite,
  output logic [REG_ADDR_W-1:0] id_ex_rs,
  output logic [REG_ADDR_W-1:0] id_ex_rt,
  output logic [REG_ADDR_W-1:0] id_ex_rd,
  output logic [ALUOP_W-1:0]    id_ex_alu_op,
  output logic [DATA_W-1:0]     id_ex_rs_data,
  output logic [DATA_W-1:0]     id_ex_rt_data,
  output logic [DATA_W-1:0]     id_ex_imm
`ifdef ID_EX_STATS_EN
  ,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
`endif
);

  id_ex_t q;
  id_ex_t id_load;
  logic   lu;

  load_use_detect u_lu (
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_valid   (q.valid),
    .ex_memread (q.memread),
    .ex_rd      (q.rd),
    .lu_c       (lu)
  );

  // Flush kills the stalled instruction upstream too, so it must not stall.
  assign stall = (lu || ex_hold) && !flush;

  // ID payload; control bits are masked off for an invalid slot.
  always_comb begin
    id_load          = ID_EX_BUBBLE;
    id_load.valid    = id_valid;
    id_load.regwrite = id_valid && id_regwrite;
    id_load.memread  = id_valid && id_memread;
    id_load.memwrite = id_valid && id_memwrite;
    id_load.rs       = id_rs;
    id_load.rt       = id_rt;
    id_load.rd       = id_rd;
    id_load.alu_op   = PIPE_ALUOP_W'(id_alu_op);
    id_load.rs_data  = PIPE_DATA_W'(id_rs_data);
    id_load.rt_data  = PIPE_DATA_W'(id_rt_data);
    id_load.imm      = PIPE_DATA_W'(id_imm);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q <= ID_EX_BUBBLE;
    end else if (!ex_hold) begin
      q <= lu ? ID_EX_BUBBLE : id_load;
    end
  end

  assign id_ex_valid    = q.valid;
  assign id_ex_regwrite = q.regwrite;
  assign id_ex_memread  = q.memread;
  assign id_ex_memwrite = q.memwrite;
  assign id_ex_rs       = q.rs;
  assign id_ex_rt       = q.rt;
  assign id_ex_rd       = q.rd;
  assign id_ex_alu_op   = ALUOP_W'(q.alu_op);
  assign id_ex_rs_data  = DATA_W'(q.rs_data);
  assign id_ex_rt_data  = DATA_W'(q.rt_data);
  assign id_ex_imm      = DATA_W'(q.imm);

`ifdef ID_EX_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (lu && !flush && !ex_hold && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      if (flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized + directed bench for id_ex_stage against a behavioural model.
// Counter checks are compiled in only when ID_EX_STATS_EN is defined.
module tb_id_ex_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_uses_rt, id_regwrite, id_memread, id_memwrite;
  logic [2:0] id_rs, id_rt, id_rd, id_alu_op;
  logic [7:0] id_rs_data, id_rt_data, id_imm;
  logic       flush, ex_hold;
  logic       stall, id_ex_valid, id_ex_regwrite, id_ex_memread, id_ex_memwrite;
  logic [2:0] id_ex_rs, id_ex_rt, id_ex_rd, id_ex_alu_op;
  logic [7:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm;
`ifdef ID_EX_STATS_EN
  logic [15:0] stall_count, flush_count;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_alu_op(id_alu_op), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .flush(flush), .ex_hold(ex_hold),
    .stall(stall), .id_ex_valid(id_ex_valid), .id_ex_regwrite(id_ex_regwrite),
    .id_ex_memread(id_ex_memread), .id_ex_memwrite(id_ex_memwrite), .id_ex_rs(id_ex_rs),
    .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd), .id_ex_alu_op(id_ex_alu_op),
    .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm)
`ifdef ID_EX_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  // Model of what the EX stage must currently see.
  logic       m_valid, m_regwrite, m_memread, m_memwrite;
  logic [2:0] m_rs, m_rt, m_rd, m_alu;
  logic [7:0] m_rsd, m_rtd, m_imm;
  int         m_stall_cnt, m_flush_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_lu();
    return id_valid && m_valid && m_memread && (m_rd != 3'd0) &&
           ((m_rd == id_rs) || (id_uses_rt && (m_rd == id_rt)));
  endfunction

  task automatic model_bubble();
    {m_valid, m_regwrite, m_memread, m_memwrite} = 4'b0;
    {m_rs, m_rt, m_rd, m_alu} = 12'b0;
    {m_rsd, m_rtd, m_imm} = 24'b0;
  endtask

  always @(posedge clk) begin : model
    bit l;
    l = model_lu();
    if (rst) begin
      model_bubble();
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (l && !flush && !ex_hold && m_stall_cnt < 65535) m_stall_cnt++;
      if (flush && m_flush_cnt < 65535) m_flush_cnt++;
      if (flush || (!ex_hold && l)) model_bubble();
      else if (!ex_hold) begin
        m_valid    = id_valid;
        m_regwrite = id_valid && id_regwrite;
        m_memread  = id_valid && id_memread;
        m_memwrite = id_valid && id_memwrite;
        m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_alu = id_alu_op;
        m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (checking) begin
      chk("stall", 32'(stall), 32'((model_lu() || ex_hold) && !flush));
      chk("ctrl", 32'({id_ex_valid, id_ex_regwrite, id_ex_memread, id_ex_memwrite}),
          32'({m_valid, m_regwrite, m_memread, m_memwrite}));
      chk("addr", 32'({id_ex_rs, id_ex_rt, id_ex_rd, id_ex_alu_op}), 32'({m_rs, m_rt, m_rd, m_alu}));
      chk("data", 32'({id_ex_rs_data, id_ex_rt_data, id_ex_imm}), 32'({m_rsd, m_rtd, m_imm}));
`ifdef ID_EX_STATS_EN
      chk("stall_count", 32'(stall_count), 32'(m_stall_cnt));
      chk("flush_count", 32'(flush_count), 32'(m_flush_cnt));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                        input logic urt, input logic rw, input logic mr, input logic [7:0] rsd);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = urt;
    id_regwrite = rw; id_memread = mr; id_memwrite = 1'b0; id_alu_op = 3'd1;
    id_rs_data = rsd; id_rt_data = rsd ^ 8'hFF; id_imm = 8'h04;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
    set_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    tick();
    chk("reset_valid", 32'(id_ex_valid), 32'd0);
    chk("reset_rs_data", 32'(id_ex_rs_data), 32'd0);
    rst = 1'b0;
    checking = 1'b1;

    // Independent ADDs
    set_id(1'b1, 3'd1, 3'd2, 3'd6, 1'b1, 1'b1, 1'b0, 8'h11);
    #1 chk("add1_stall", 32'(stall), 32'd0);
    tick();
    chk("add1_rs", 32'(id_ex_rs), 32'd1);
    chk("add1_rs_data", 32'(id_ex_rs_data), 32'h11);
    set_id(1'b1, 3'd3, 3'd4, 3'd7, 1'b1, 1'b1, 1'b0, 8'h33);
    tick();
    chk("add2_rt", 32'(id_ex_rt), 32'd4);
    chk("add2_rt_data", 32'(id_ex_rt_data), 32'hCC);

    // Load-use on rs
    set_id(1'b1, 3'd0, 3'd0, 3'd3, 1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    set_id(1'b1, 3'd3, 3'd1, 3'd4, 1'b1, 1'b1, 1'b0, 8'h5A);
    #1 chk("lu_stall", 32'(stall), 32'd1);
    tick();
    chk("lu_bubble", 32'(id_ex_valid), 32'd0);
    chk("lu_stall_drop", 32'(stall), 32'd0);
    tick();
    chk("lu_advance", 32'(id_ex_rs_data), 32'h5A);
`ifdef ID_EX_STATS_EN
    chk("lu_stall_count", 32'(stall_count), 32'd1);
`endif

    // Load with rd=0
    set_id(1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    set_id(1'b1, 3'd0, 3'd0, 3'd2, 1'b1, 1'b1, 1'b0, 8'h01);
    #1 chk("rd0_stall", 32'(stall), 32'd0);

    // rt not read
    tick();
    set_id(1'b1, 3'd1, 3'd0, 3'd5, 1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    set_id(1'b1, 3'd1, 3'd5, 3'd2, 1'b0, 1'b1, 1'b0, 8'h02);
    #1 chk("rt_unused_stall", 32'(stall), 32'd0);

    // Flush with load-use
    tick();
    set_id(1'b1, 3'd1, 3'd0, 3'd2, 1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    set_id(1'b1, 3'd2, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 8'h03);
    flush = 1'b1;
    #1 chk("flush_stall", 32'(stall), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_bubble", 32'(id_ex_valid), 32'd0);
`ifdef ID_EX_STATS_EN
    chk("flush_count", 32'(flush_count), 32'd1);
`endif

    // Hold then reset mid-hold
    set_id(1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, 8'hA5);
    tick();
    set_id(1'b1, 3'd6, 3'd7, 3'd1, 1'b1, 1'b1, 1'b0, 8'h3C);
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_stall", 32'(stall), 32'd1);
      tick();
      chk("hold_rs_data", 32'(id_ex_rs_data), 32'hA5);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; ex_hold = 1'b0;
    #1;
    chk("rst_hold_valid", 32'(id_ex_valid), 32'd0);
    chk("rst_hold_rs_data", 32'(id_ex_rs_data), 32'd0);
    chk("rst_hold_stall", 32'(stall), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      id_valid    = ($urandom_range(0, 9) < 8);
      id_rs       = 3'($urandom_range(0, 7));
      id_rt       = 3'($urandom_range(0, 7));
      id_rd       = 3'($urandom_range(0, 7));
      id_uses_rt  = 1'($urandom_range(0, 1));
      id_regwrite = 1'($urandom_range(0, 1));
      id_memread  = 1'($urandom_range(0, 1));
      id_memwrite = 1'($urandom_range(0, 1));
      id_alu_op   = 3'($urandom_range(0, 7));
      id_rs_data  = 8'($urandom);
      id_rt_data  = 8'($urandom);
      id_imm      = 8'($urandom);
      flush       = ($urandom_range(0, 9) == 0);
      ex_hold     = ($urandom_range(0, 7) == 0);
      rst         = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    tick();
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
